// File: rtl/bayer_stream_gen_if.sv
// Pixel-stream bundle for bayer_stream_gen: control inputs plus the raw Bayer output stream.
// iSTALL exists only when BAYER_GEN_STALL_EN is defined.
interface bayer_stream_gen_if #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 11
);
    logic              iEN;
    logic [1:0]        iMODE;
`ifdef BAYER_GEN_STALL_EN
    logic              iSTALL;
`endif
    logic [CNT_W-1:0]  oX_Cont;
    logic [CNT_W-1:0]  oY_Cont;
    logic [DATA_W-1:0] oDATA;
    logic              oDVAL;
    logic              oFVAL;
    logic              oFRAME_DONE;
    logic [7:0]        oFRAME_CNT;

    modport master (
        input  iEN, iMODE,
`ifdef BAYER_GEN_STALL_EN
        input  iSTALL,
`endif
        output oX_Cont, oY_Cont, oDATA, oDVAL, oFVAL, oFRAME_DONE, oFRAME_CNT
    );

    modport slave (
        output iEN, iMODE,
`ifdef BAYER_GEN_STALL_EN
        output iSTALL,
`endif
        input  oX_Cont, oY_Cont, oDATA, oDVAL, oFVAL, oFRAME_DONE, oFRAME_CNT
    );
endinterface

// File: rtl/bayer_stream_gen.sv
// Raw-Bayer test-pattern source with programmable frame timing (ramp, CFA-ID, checker, LFSR).
// Optional BAYER_GEN_STALL_EN adds iSTALL back-pressure during the active part of a line.
module bayer_stream_gen #(
    parameter int unsigned H_ACTIVE = 8,
    parameter int unsigned V_ACTIVE = 6,
    parameter int unsigned H_BLANK  = 2,
    parameter int unsigned V_BLANK  = 2,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    bayer_stream_gen_if.master   bus
);
    localparam int unsigned VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int unsigned BLK_W  = $clog2(VB_LEN + 1);
    localparam logic [11:0] SEED   = 12'hACE;

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    x_q, x_d, y_q, y_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                dval_q, dval_d, fval_q, fval_d, done_q, done_d;
    logic [7:0]          fcnt_q, fcnt_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   n_q, n_d;
    logic [11:0]         lfsr_q, lfsr_d;
    logic [BLK_W-1:0]    blk_q, blk_d;

    logic stall, line_end, hb_end, vb_end, last_line;
    logic frame_start, line_start, frame_end, pix_next, pres;
    logic [CNT_W-1:0]  pres_x, pres_y;
    logic [DATA_W-1:0] pres_n;
    logic [11:0]       pres_lfsr;
    logic [1:0]        pres_mode;

`ifdef BAYER_GEN_STALL_EN
    assign stall = bus.iSTALL;
`else
    assign stall = 1'b0;
`endif

    function automatic logic [11:0] lfsr_step(input logic [11:0] l);
        return {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
    endfunction

    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [CNT_W-1:0]  px,
        input logic [CNT_W-1:0]  py,
        input logic [DATA_W-1:0] pn,
        input logic [11:0]       pl
    );
        logic [DATA_W-1:0] g;
        g = DATA_W'(1) << (DATA_W - 1);
        case (m)
            2'd0: return pn + DATA_W'(1);
            2'd1: begin
                case ({py[0], px[0]})
                    2'b00:   return g;
                    2'b01:   return '1;
                    2'b10:   return '0;
                    default: return g;
                endcase
            end
            2'd2:    return (px[2] ^ py[2]) ? '1 : '0;
            default: return DATA_W'(pl);
        endcase
    endfunction

    // Outputs show the pixel just presented; the next pixel is chosen from the current state.
    assign last_line   = (y_q == CNT_W'(V_ACTIVE - 1));
    assign line_end    = (state_q == ACTIVE) && (x_q == CNT_W'(H_ACTIVE - 1));
    assign hb_end      = (state_q == HBLANK) && (blk_q == BLK_W'(H_BLANK));
    assign vb_end      = (state_q == VBLANK) && (blk_q == BLK_W'(VB_LEN));
    assign frame_start = bus.iEN && ((state_q == IDLE) || vb_end);
    assign line_start  = hb_end && !last_line;
    assign frame_end   = hb_end && last_line;
    assign pix_next    = (state_q == ACTIVE) && !line_end && !stall;
    assign pres        = frame_start || line_start || pix_next;

    assign pres_x    = pix_next ? x_q + CNT_W'(1) : '0;
    assign pres_y    = frame_start ? '0 : (line_start ? y_q + CNT_W'(1) : y_q);
    assign pres_n    = frame_start ? '0 : n_q;
    assign pres_lfsr = frame_start ? SEED : lfsr_q;
    assign pres_mode = frame_start ? bus.iMODE : mode_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.iEN) state_d = ACTIVE;
            ACTIVE:  if (line_end) state_d = HBLANK;
            HBLANK:  if (hb_end) state_d = last_line ? VBLANK : ACTIVE;
            VBLANK:  if (vb_end) state_d = bus.iEN ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        data_d = data_q;
        dval_d = 1'b0;
        fval_d = fval_q;
        done_d = 1'b0;
        fcnt_d = fcnt_q;
        mode_d = mode_q;
        n_d    = n_q;
        lfsr_d = lfsr_q;
        blk_d  = blk_q;
        if (pres) begin
            x_d    = pres_x;
            y_d    = pres_y;
            data_d = pattern(pres_mode, pres_x, pres_y, pres_n, pres_lfsr);
            dval_d = 1'b1;
            fval_d = 1'b1;
            mode_d = pres_mode;
            n_d    = pres_n + DATA_W'(1);
            lfsr_d = lfsr_step(pres_lfsr);
        end
        if (line_end) blk_d = BLK_W'(1);
        if ((state_q == HBLANK && !hb_end) || (state_q == VBLANK && !vb_end))
            blk_d = blk_q + BLK_W'(1);
        if (frame_end) begin
            x_d    = '0;
            y_d    = '0;
            fval_d = 1'b0;
            done_d = 1'b1;
            fcnt_d = fcnt_q + 8'd1;
            blk_d  = BLK_W'(1);
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_q    <= '0;
            y_q    <= '0;
            data_q <= '0;
            dval_q <= 1'b0;
            fval_q <= 1'b0;
            done_q <= 1'b0;
            fcnt_q <= '0;
            mode_q <= '0;
            n_q    <= '0;
            lfsr_q <= SEED;
            blk_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            data_q <= data_d;
            dval_q <= dval_d;
            fval_q <= fval_d;
            done_q <= done_d;
            fcnt_q <= fcnt_d;
            mode_q <= mode_d;
            n_q    <= n_d;
            lfsr_q <= lfsr_d;
            blk_q  <= blk_d;
        end
    end

    assign bus.oX_Cont     = x_q;
    assign bus.oY_Cont     = y_q;
    assign bus.oDATA       = data_q;
    assign bus.oDVAL       = dval_q;
    assign bus.oFVAL       = fval_q;
    assign bus.oFRAME_DONE = done_q;
    assign bus.oFRAME_CNT  = fcnt_q;
endmodule

// File: tb/tb_bayer_stream_gen.sv
// Bench for bayer_stream_gen: frame-position reference model, spec-constant vector table,
// randomized enable/mode stimulus, and hand-written reset and stall sequences.
module tb_bayer_stream_gen;
    localparam int HA = 8, VA = 6, HB = 2, VB = 2, DW = 12, CW = 11;
    localparam int LINE  = HA + HB;
    localparam int FRAME = (VA + VB) * LINE;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bayer_stream_gen_if #(.DATA_W(DW), .CNT_W(CW)) bus();

    bayer_stream_gen #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB),
        .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus(bus)
    );

    typedef struct {
        int          mode;
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;
    vec_t vt[12];

    int checks = 0, errors = 0;
    int cyc = 0, pix_cnt = 0;
    bit use_model = 1;
    int starts[$];
    logic [DW-1:0] cap[VA][HA];
    logic [11:0] lseq[HA*VA];

    // reference model: position inside the current frame period
    bit            m_busy;
    int            m_pos, m_mode;
    logic [CW-1:0] m_x, m_y;
    logic [DW-1:0] m_data;
    logic          m_dval, m_fval, m_done;
    logic [7:0]    m_fcnt;

    function automatic logic [DW-1:0] pat(int md, int x, int y);
        int n;
        n = y * HA + x;
        case (md)
            0: return DW'(n + 1);
            1: if (y % 2 == 0) return (x % 2 == 0) ? 12'h800 : 12'hFFF;
               else            return (x % 2 == 0) ? 12'h000 : 12'h800;
            2: return (((x / 4) % 2) != ((y / 4) % 2)) ? 12'hFFF : 12'h000;
            default: return lseq[n];
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_mode = 0;
        m_x = '0; m_y = '0; m_data = '0;
        m_dval = 0; m_fval = 0; m_done = 0; m_fcnt = '0;
    endtask

    task automatic model_step();
        bit en;
        int md, line, col;
        en = bus.iEN;
        md = int'(bus.iMODE);
        m_done = 0;
        if (!m_busy) begin
            if (en) begin m_busy = 1; m_pos = 0; m_mode = md; end
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                if (en) begin m_pos = 0; m_mode = md; end
                else m_busy = 0;
            end
        end
        if (m_busy) begin
            line = m_pos / LINE;
            col  = m_pos % LINE;
            if (line < VA) begin
                m_fval = 1;
                if (col < HA) begin
                    m_dval = 1; m_x = CW'(col); m_y = CW'(line);
                    m_data = pat(m_mode, col, line);
                end else m_dval = 0;
            end else begin
                m_dval = 0; m_fval = 0; m_x = '0; m_y = '0;
                if (m_pos == VA * LINE) begin m_done = 1; m_fcnt++; end
            end
        end else begin
            m_dval = 0; m_fval = 0;
        end
    endtask

    task automatic compare_all();
        check("oDVAL", 32'(bus.oDVAL), 32'(m_dval));
        check("oFVAL", 32'(bus.oFVAL), 32'(m_fval));
        check("oFRAME_DONE", 32'(bus.oFRAME_DONE), 32'(m_done));
        check("oFRAME_CNT", 32'(bus.oFRAME_CNT), 32'(m_fcnt));
        check("oX_Cont", 32'(bus.oX_Cont), 32'(m_x));
        check("oY_Cont", 32'(bus.oY_Cont), 32'(m_y));
        check("oDATA", 32'(bus.oDATA), 32'(m_data));
    endtask

    task automatic tick();
        @(posedge clk);
        if (use_model) model_step();
        #1;
        cyc++;
        if (use_model) compare_all();
        if (bus.oDVAL) begin
            pix_cnt++;
            if (int'(bus.oX_Cont) < HA && int'(bus.oY_Cont) < VA)
                cap[bus.oY_Cont][bus.oX_Cont] = bus.oDATA;
            if (bus.oX_Cont == '0 && bus.oY_Cont == '0) starts.push_back(cyc);
        end
    endtask

    task automatic run_idle();
        bus.iEN = 0;
        repeat (FRAME + 2) tick();
    endtask

    task automatic wait_pix(input int x, input int y);
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (bus.oDVAL && int'(bus.oX_Cont) == x && int'(bus.oY_Cont) == y) found = 1;
            else tick();
        end
        check($sformatf("wait_pix_%0d_%0d", x, y), 32'(found), 32'd1);
    endtask

    task automatic wait_done();
        bit found;
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (bus.oFRAME_DONE) found = 1;
        end
        check("wait_frame_done", 32'(found), 32'd1);
    endtask

    task automatic check_table(input int md);
        for (int i = 0; i < 12; i++)
            if (vt[i].mode == md)
                check($sformatf("vec_m%0d_x%0d_y%0d", md, vt[i].x, vt[i].y),
                      32'(cap[vt[i].y][vt[i].x]), 32'(vt[i].exp));
    endtask

    task automatic clear_cap();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) cap[y][x] = 'x;
    endtask

    initial begin
        logic [11:0] l;
        vt[0]  = '{0, 0, 0, 12'h001};  vt[1]  = '{0, 7, 0, 12'h008};
        vt[2]  = '{0, 0, 1, 12'h009};  vt[3]  = '{0, 7, 5, 12'h030};
        vt[4]  = '{1, 0, 0, 12'h800};  vt[5]  = '{1, 1, 0, 12'hFFF};
        vt[6]  = '{1, 0, 1, 12'h000};  vt[7]  = '{1, 1, 1, 12'h800};
        vt[8]  = '{2, 4, 0, 12'hFFF};  vt[9]  = '{2, 0, 4, 12'hFFF};
        vt[10] = '{2, 4, 4, 12'h000};  vt[11] = '{3, 0, 0, 12'hACE};

        l = 12'hACE;
        for (int i = 0; i < HA * VA; i++) begin
            lseq[i] = l;
            l = {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
        end

        rst = 1; bus.iEN = 0; bus.iMODE = 0;
`ifdef BAYER_GEN_STALL_EN
        bus.iSTALL = 0;
`endif
        model_reset();
        clear_cap();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 0;
        repeat (3) tick();

        // one frame of ramp, enable dropped right after start
        bus.iEN = 1; bus.iMODE = 0; pix_cnt = 0;
        tick();
        bus.iEN = 0;
        repeat (FRAME + 5) tick();
        check("t1_pixel_count", 32'(pix_cnt), 32'd48);
        check("t1_frame_cnt", 32'(bus.oFRAME_CNT), 32'd1);
        check_table(0);

        // CFA-ID, enable held for two frames
        bus.iEN = 1; bus.iMODE = 1;
        starts.delete();
        repeat (2 * FRAME + 2) tick();
        check("t2_frame_len", (starts.size() >= 2) ? 32'(starts[1] - starts[0]) : 32'd0, 32'd80);
        check_table(1);
        run_idle();

        // mode switch mid-frame only takes effect next frame
        bus.iEN = 1; bus.iMODE = 0;
        clear_cap();
        wait_pix(3, 2);
        bus.iMODE = 2;
        wait_done();
        check("t3_ramp_last", 32'(cap[5][7]), 32'h030);
        clear_cap();
        repeat (FRAME) tick();
        bus.iEN = 0;
        check_table(2);
        run_idle();

        // LFSR, two frames, reseeded at each frame start
        bus.iEN = 1; bus.iMODE = 3;
        repeat (2 * FRAME) tick();
        check_table(3);
        run_idle();

        // asynchronous reset mid-frame with enable held
        bus.iEN = 1; bus.iMODE = 0;
        wait_pix(5, 3);
        #2 rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 rst = 0;
        tick();
        check("t5_restart_data", 32'(bus.oDATA), 32'd1);
        check("t5_restart_xy", 32'({bus.oX_Cont, bus.oY_Cont}), 32'd0);
        check("t5_frame_cnt", 32'(bus.oFRAME_CNT), 32'd0);
        wait_done();
        run_idle();

        // randomized enable and mode
        for (int i = 0; i < 8 * FRAME; i++) begin
            tick();
            bus.iEN   = ($urandom_range(0, 9) != 0);
            bus.iMODE = 2'($urandom_range(0, 3));
        end
        run_idle();

`ifdef BAYER_GEN_STALL_EN
        bus.iEN = 1; bus.iMODE = 0;
        wait_pix(1, 1);
        use_model = 0;
        bus.iSTALL = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_dval_low", 32'(bus.oDVAL), 32'd0);
        end
        bus.iSTALL = 0;
        for (int k = 2; k < HA; k++) begin
            tick();
            check($sformatf("stall_dval_x%0d", k), 32'(bus.oDVAL), 32'd1);
            check($sformatf("stall_x%0d", k), 32'(bus.oX_Cont), 32'(k));
            check($sformatf("stall_y_x%0d", k), 32'(bus.oY_Cont), 32'd1);
            check($sformatf("stall_data_x%0d", k), 32'(bus.oDATA), 32'(HA + k + 1));
        end
        tick();
        check("stall_line_end", 32'(bus.oDVAL), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
